// File: rtl/pe_result_drain_pkg.sv
// Shared definitions for the PE result drain.
//   DEF_NUM_PE / DEF_DATA_W / DEF_ADDR_W : default PE count, result width, SRAM address width
//   drain_state_t                        : drain controller states
package pe_result_drain_pkg;

  localparam int unsigned DEF_NUM_PE = 5;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FINISH
  } drain_state_t;

endpackage

// File: rtl/pe_result_drain_if.sv
// Handshake bundle between the drain, the PE row and the output SRAM write port.
//   peValid/peData/peAck : per-PE result offer and one-hot accept
//   wrValid/wrReady      : SRAM write handshake
//   wrAddr/wrData        : SRAM write address and data
// Modport master is the drain itself; slave is the PE row plus SRAM side.
interface pe_result_drain_if
  import pe_result_drain_pkg::*;
#(
  parameter int unsigned NUM_PE = DEF_NUM_PE,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  logic [NUM_PE-1:0]        peValid;
  logic [NUM_PE*DATA_W-1:0] peData;
  logic [NUM_PE-1:0]        peAck;
  logic                     wrValid;
  logic                     wrReady;
  logic [ADDR_W-1:0]        wrAddr;
  logic [DATA_W-1:0]        wrData;

  modport master (
    input  peValid, peData, wrReady,
    output peAck, wrValid, wrAddr, wrData
  );

  modport slave (
    output peValid, peData, wrReady,
    input  peAck, wrValid, wrAddr, wrData
  );

endinterface

// File: rtl/pe_result_drain_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index (must be < N)
//   gnt       : one-hot grant
//   gnt_idx   : index of the granted requester
//   gnt_valid : any requester granted
module pe_result_drain_rr_arbiter #(
  parameter int unsigned N    = 5,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    logic [IdxW:0] pos;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    pos       = '0;
    // Walk from ptr upward, wrapping at N; first requester wins.
    for (int unsigned off = 0; off < N; off++) begin
      pos = {1'b0, ptr} + (IdxW + 1)'(off);
      if (pos >= (IdxW + 1)'(N)) begin
        pos = pos - (IdxW + 1)'(N);
      end
      if (!gnt_valid && req[pos[IdxW-1:0]]) begin
        gnt_valid             = 1'b1;
        gnt[pos[IdxW-1:0]]    = 1'b1;
        gnt_idx               = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Drains finished partial sums from the PE row into the single output SRAM write port.
//   clk, nRST           : clock, asynchronous active-low reset
//   start               : job start pulse (only honoured in IDLE)
//   rowLen/colTiles     : results per PE per tile / tiles per job, captured on start
//   baseAddr            : first output address, captured on start
//   bus (master)        : PE offers/acks and SRAM write handshake
//   busy                : high while draining
//   done                : one-cycle pulse when the last write of the job is accepted
module pe_result_drain
  import pe_result_drain_pkg::*;
#(
  parameter int unsigned NUM_PE = DEF_NUM_PE,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              start,
  input  logic [7:0]        rowLen,
  input  logic [6:0]        colTiles,
  input  logic [ADDR_W-1:0] baseAddr,
  pe_result_drain_if.master bus,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  drain_state_t      state;
  logic [7:0]        row_len_q;
  logic [6:0]        col_tiles_q;
  logic [6:0]        tile_cnt_q;
  logic [ADDR_W-1:0] ptr_q     [NUM_PE];
  logic [7:0]        row_cnt_q [NUM_PE];
  logic [IDX_W-1:0]  rr_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;

  logic [NUM_PE-1:0] row_full;
  logic [NUM_PE-1:0] eligible;
  logic [NUM_PE-1:0] req;
  logic [NUM_PE-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic              space;
  logic              tile_done;
  logic [DATA_W-1:0] gnt_data;
  logic [ADDR_W-1:0] gnt_addr;

  // A PE that has delivered its whole row for this tile is masked until the barrier.
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      row_full[i] = (row_cnt_q[i] == row_len_q);
      eligible[i] = bus.peValid[i] & ~row_full[i];
    end
  end

  assign space     = ~wr_valid_q | bus.wrReady;
  assign req       = ((state == DRAIN) && space) ? eligible : '0;
  assign tile_done = &row_full;

  pe_result_drain_rr_arbiter #(
    .N    (NUM_PE),
    .IdxW (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // One-hot mux of the granted PE's data and address pointer.
  always_comb begin
    gnt_data = '0;
    gnt_addr = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (gnt[i]) begin
        gnt_data = gnt_data | bus.peData[i*DATA_W +: DATA_W];
        gnt_addr = gnt_addr | ptr_q[i];
      end
    end
  end

  assign bus.peAck   = gnt;
  assign bus.wrValid = wr_valid_q;
  assign bus.wrAddr  = wr_addr_q;
  assign bus.wrData  = wr_data_q;
  assign busy        = (state == DRAIN);
  assign done        = done_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      row_len_q   <= '0;
      col_tiles_q <= '0;
      tile_cnt_q  <= '0;
      rr_q        <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) begin
        ptr_q[i]     <= '0;
        row_cnt_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // A new grant below overrides this clear.
      if (wr_valid_q && bus.wrReady) begin
        wr_valid_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            row_len_q   <= rowLen;
            col_tiles_q <= colTiles;
            tile_cnt_q  <= '0;
            for (int i = 0; i < NUM_PE; i++) begin
              ptr_q[i]     <= baseAddr + ADDR_W'(i);
              row_cnt_q[i] <= '0;
            end
            state <= ((rowLen == 8'd0) || (colTiles == 7'd0)) ? FINISH : DRAIN;
          end
        end

        DRAIN: begin
          if (gnt_valid) begin
            wr_valid_q <= 1'b1;
            wr_data_q  <= gnt_data;
            wr_addr_q  <= gnt_addr;
            // Per-PE pointer stride of NUM_PE keeps the output row-major without a multiplier.
            for (int i = 0; i < NUM_PE; i++) begin
              if (gnt[i]) begin
                ptr_q[i]     <= ptr_q[i] + ADDR_W'(NUM_PE);
                row_cnt_q[i] <= row_cnt_q[i] + 8'd1;
              end
            end
            rr_q <= (gnt_idx == IDX_W'(NUM_PE - 1)) ? '0 : gnt_idx + 1'b1;
          end else if (tile_done) begin
            for (int i = 0; i < NUM_PE; i++) begin
              row_cnt_q[i] <= '0;
            end
            tile_cnt_q <= tile_cnt_q + 7'd1;
            if ((tile_cnt_q + 7'd1) == col_tiles_q) begin
              state <= FINISH;
            end
          end
        end

        FINISH: begin
          if (!wr_valid_q) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Randomised bench for pe_result_drain with a cycle-level reference model and a
// write scoreboard. Expected writes are pushed when the model grants a PE; an
// independent monitor pops and compares on every accepted SRAM write.
module tb_pe_result_drain;

  localparam int NPE = 5;
  localparam int MAXR = 64;

  logic        clk = 1'b0;
  logic        nRST;
  logic        start;
  logic [7:0]  rowLen;
  logic [6:0]  colTiles;
  logic [13:0] baseAddr;
  logic        busy;
  logic        done;

  pe_result_drain_if bus ();

  pe_result_drain dut (
    .clk      (clk),
    .nRST     (nRST),
    .start    (start),
    .rowLen   (rowLen),
    .colTiles (colTiles),
    .baseAddr (baseAddr),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard
  logic [13:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];

  // Reference model state
  int          m_state;  // 0 idle, 1 draining, 2 finishing
  int          m_rl, m_ct, m_tile, m_rr;
  int          m_base;
  int          m_cnt[NPE];
  bit          m_pend, m_done;

  // Stimulus state
  logic [15:0] pe_res[NPE][MAXR];
  int          pe_next[NPE];
  int          pe_total;
  int          pe_prob[NPE];
  bit          acked[NPE];
  logic [NPE-1:0] pv;
  logic [NPE-1:0] first_mask;
  int          mask_drives;
  int          ready_prob, stall_lo, stall_hi, cyc;
  int          start_req;  // 0 none, 1 real job, 2 decoy
  int          job_rl, job_ct, job_base;

  // Monitor state
  int          wr_cnt, done_cnt;
  logic [13:0] max_addr;
  bit          hold_prev;
  logic [13:0] prev_a;
  logic [15:0] prev_d;

  task automatic drive();
    logic [NPE*16-1:0] pd;
    start = (start_req != 0);
    if (start_req == 1) begin
      rowLen   = 8'(job_rl);
      colTiles = 7'(job_ct);
      baseAddr = 14'(job_base);
    end else begin
      rowLen   = 8'($urandom);
      colTiles = 7'($urandom);
      baseAddr = 14'($urandom);
    end
    start_req = 0;
    pd = '0;
    for (int i = 0; i < NPE; i++) begin
      if (acked[i]) begin
        pv[i]    = 1'b0;
        acked[i] = 1'b0;
      end
      if (!pv[i] && pe_next[i] < pe_total && ($urandom_range(99) < 32'(pe_prob[i])) &&
          (mask_drives == 0 || first_mask[i])) begin
        pv[i] = 1'b1;
      end
      pd[i*16 +: 16] = pv[i] ? pe_res[i][pe_next[i]] : 16'($urandom);
    end
    if (mask_drives > 0) mask_drives--;
    bus.peValid = pv;
    bus.peData  = pd;
    if (cyc >= stall_lo && cyc < stall_hi) bus.wrReady = 1'b0;
    else bus.wrReady = ($urandom_range(99) < 32'(ready_prob));
    cyc++;
  endtask

  task automatic tick();
    int g;
    bit sp, all_full;
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("done", 32'(done), 32'(m_done));
    chk("wrValid", 32'(bus.wrValid), 32'(m_pend));
    m_done = 1'b0;
    g = -1;
    sp = !m_pend || bus.wrReady;
    if (m_state == 1 && sp) begin
      for (int off = 0; off < NPE; off++) begin
        int i;
        i = (m_rr + off) % NPE;
        if (g < 0 && pv[i] && m_cnt[i] != m_rl) g = i;
      end
    end
    chk("peAck", 32'(bus.peAck), (g >= 0) ? (32'd1 << g) : 32'd0);
    case (m_state)
      0: begin
        if (start) begin
          m_rl   = int'(rowLen);
          m_ct   = int'(colTiles);
          m_base = int'(baseAddr);
          m_tile = 0;
          for (int i = 0; i < NPE; i++) m_cnt[i] = 0;
          m_state = (m_rl == 0 || m_ct == 0) ? 2 : 1;
        end
      end
      1: begin
        if (g >= 0) begin
          // Row-major output: PE g's k-th result of tile t lands at base + (t*rowLen+k)*NPE + g.
          exp_addr_q.push_back(14'(m_base + (m_tile * m_rl + m_cnt[g]) * NPE + g));
          exp_data_q.push_back(pe_res[g][pe_next[g]]);
          m_cnt[g]++;
          m_rr = (g + 1) % NPE;
          m_pend = 1'b1;
          acked[g] = 1'b1;
          pe_next[g]++;
        end else begin
          if (bus.wrReady) m_pend = 1'b0;
          all_full = 1'b1;
          for (int i = 0; i < NPE; i++) if (m_cnt[i] != m_rl) all_full = 1'b0;
          if (all_full) begin
            for (int i = 0; i < NPE; i++) m_cnt[i] = 0;
            m_tile++;
            if (m_tile == m_ct) m_state = 2;
          end
        end
      end
      default: begin
        if (!m_pend) begin
          m_done  = 1'b1;
          m_state = 0;
        end else if (bus.wrReady) begin
          m_pend = 1'b0;
        end
      end
    endcase
    @(posedge clk);
    #1;
    drive();
  endtask

  // Write monitor
  initial begin
    logic [13:0] ea;
    logic [15:0] ed;
    forever begin
      @(negedge clk);
      if (!nRST) begin
        hold_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (hold_prev) begin
          chk("hold_addr", 32'(bus.wrAddr), 32'(prev_a));
          chk("hold_data", 32'(bus.wrData), 32'(prev_d));
        end
        hold_prev = 1'b0;
        if (bus.wrValid) begin
          if (bus.wrReady) begin
            chk("sb_has_entry", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
              ea = exp_addr_q.pop_front();
              ed = exp_data_q.pop_front();
              chk("wr_addr", 32'(bus.wrAddr), 32'(ea));
              chk("wr_data", 32'(bus.wrData), 32'(ed));
            end
            wr_cnt++;
            if (bus.wrAddr > max_addr) max_addr = bus.wrAddr;
          end else begin
            hold_prev = 1'b1;
            prev_a    = bus.wrAddr;
            prev_d    = bus.wrData;
          end
        end
      end
    end
  end

  task automatic do_abort();
    #2;
    nRST = 1'b0;
    #1;
    chk("rst_wrValid", 32'(bus.wrValid), 32'd0);
    chk("rst_peAck", 32'(bus.peAck), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrAddr", 32'(bus.wrAddr), 32'd0);
    chk("rst_wrData", 32'(bus.wrData), 32'd0);
    m_state = 0;
    m_pend  = 1'b0;
    m_done  = 1'b0;
    m_rr    = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    pv = '0;
    bus.peValid = '0;
    for (int i = 0; i < NPE; i++) acked[i] = 1'b0;
    pe_total  = 0;
    hold_prev = 1'b0;
    nRST = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one job from a posedge+1 point. decoy_at >= 0 pulses a start mid-drain;
  // abort_at >= 0 resets once the model expects a pending write.
  task automatic run_job(input int rl, input int ct, input int base, input int decoy_at,
                         input int abort_at);
    int n;
    job_rl   = rl;
    job_ct   = ct;
    job_base = base;
    pe_total = rl * ct;
    for (int i = 0; i < NPE; i++) begin
      pe_next[i] = 0;
      acked[i]   = 1'b0;
      for (int k = 0; k < MAXR; k++) pe_res[i][k] = 16'($urandom);
    end
    pv       = '0;
    wr_cnt   = 0;
    done_cnt = 0;
    max_addr = '0;
    cyc      = 0;
    start_req = 1;
    drive();
    tick();
    n = 0;
    while (m_state != 0 && n < 2000) begin
      if (n == decoy_at && m_state == 1) start_req = 2;
      if (abort_at >= 0 && n >= abort_at && m_pend && m_state == 1) begin
        do_abort();
        return;
      end
      tick();
      n++;
    end
    chk("job_timeout", 32'(n < 2000), 32'd1);
    tick();
    tick();
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'(rl * ct * NPE));
    chk("sb_empty", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic set_probs(input int p, input int rp);
    for (int i = 0; i < NPE; i++) pe_prob[i] = p;
    ready_prob  = rp;
    stall_lo    = -1;
    stall_hi    = -1;
    mask_drives = 0;
    first_mask  = '1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rl, ct, base;
    nRST = 1'b0;
    start = 1'b0;
    start_req = 0;
    rowLen = '0;
    colTiles = '0;
    baseAddr = '0;
    pv = '0;
    bus.peValid = '0;
    bus.peData = '0;
    bus.wrReady = 1'b0;
    m_state = 0;
    m_pend = 1'b0;
    m_done = 1'b0;
    m_rr = 0;
    pe_total = 0;
    hold_prev = 1'b0;
    set_probs(100, 100);
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_wrValid", 32'(bus.wrValid), 32'd0);
    chk("reset_peAck", 32'(bus.peAck), 32'd0);
    chk("reset_wrAddr", 32'(bus.wrAddr), 32'd0);
    chk("reset_wrData", 32'(bus.wrData), 32'd0);
    nRST = 1'b1;
    @(posedge clk);
    #1;

    // Full-rate job with a decoy start while draining.
    set_probs(100, 100);
    run_job(2, 1, 'h100, 3, -1);

    // Only PE3 offers in the first drain cycle.
    set_probs(100, 100);
    first_mask  = 5'b01000;
    mask_drives = 2;
    run_job(2, 1, 'h100, -1, -1);

    // Three-cycle write stall mid-stream.
    set_probs(100, 100);
    stall_lo = 4;
    stall_hi = 7;
    run_job(3, 2, 'h200, -1, -1);

    // PE2 races ahead into later tiles and must wait at the barrier.
    set_probs(30, 100);
    pe_prob[2] = 100;
    run_job(1, 3, 'h040, -1, -1);
    chk("tile_max_addr", 32'(max_addr), 32'h040 + 32'd14);

    // Empty job.
    set_probs(100, 100);
    run_job(0, 2, 'h010, -1, -1);

    // Reset mid-drain, then a clean job.
    set_probs(100, 70);
    run_job(4, 2, 'h300, -1, 3);
    set_probs(80, 80);
    run_job(2, 2, 'h050, -1, -1);

    // Randomised jobs, one near the top of the address space.
    for (int j = 0; j < 8; j++) begin
      rl   = $urandom_range(4);
      ct   = $urandom_range(3);
      base = (j == 3) ? 'h3FF6 : int'($urandom_range(14'h3FFF));
      set_probs(0, int'($urandom_range(100, 40)));
      for (int i = 0; i < NPE; i++) pe_prob[i] = $urandom_range(100, 20);
      if (j % 2 == 1) begin
        stall_lo = $urandom_range(8, 2);
        stall_hi = stall_lo + 3;
      end
      run_job(rl, ct, base, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
